// File: rtl/route_xbar_pkg.sv
// Shared sizing helpers and map-encoding rules for the route_xbar crossbar.
// Any selector code at or above the input width means "drive the default bit".
package route_xbar_pkg;

  function automatic int unsigned sel_width(input int unsigned in_w);
    return $clog2(in_w + 32'd1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned out_w);
    return (out_w > 32'd1) ? $clog2(out_w) : 32'd1;
  endfunction

  // Canonical unmapped code: the first code past the last input bit.
  function automatic int unsigned unmapped_code(input int unsigned in_w);
    return in_w;
  endfunction

  // Identity map entry: output bit i follows input bit i while it exists.
  function automatic int unsigned identity_entry(input int unsigned idx, input int unsigned in_w);
    return (idx < in_w) ? idx : unmapped_code(in_w);
  endfunction

endpackage

// File: rtl/route_map_bank.sv
// Shadow/active routing map storage with atomic commit and sticky
// out-of-range config error. A same-cycle write is folded into the commit.
module route_map_bank
  import route_xbar_pkg::*;
#(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SEL_W = sel_width(IN_W),
  parameter int unsigned IDX_W = idx_width(OUT_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [SEL_W-1:0]       cfg_sel,
  input  logic                   cfg_commit,
  output logic                   cfg_err,
  output logic [OUT_W*SEL_W-1:0] active_map
);

  logic [SEL_W-1:0] shadow_r      [OUT_W];
  logic [SEL_W-1:0] active_r      [OUT_W];
  logic [SEL_W-1:0] shadow_next_s [OUT_W];
  logic             idx_ok_s;
  logic             cfg_err_r;

  assign idx_ok_s = (32'(cfg_idx) < OUT_W);

  // Shadow map with this cycle's write applied.
  always_comb begin
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (cfg_we && idx_ok_s && (32'(cfg_idx) == i)) begin
        shadow_next_s[i] = cfg_sel;
      end else begin
        shadow_next_s[i] = shadow_r[i];
      end
    end
  end

  // Map registers and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < OUT_W; i++) begin
        shadow_r[i] <= SEL_W'(identity_entry(i, IN_W));
        active_r[i] <= SEL_W'(identity_entry(i, IN_W));
      end
      cfg_err_r <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < OUT_W; i++) begin
        shadow_r[i] <= shadow_next_s[i];
        if (cfg_commit) begin
          active_r[i] <= shadow_next_s[i];
        end
      end
      if (cfg_we && !idx_ok_s) begin
        cfg_err_r <= 1'b1;
      end
    end
  end

  // Flatten the active map for the datapath.
  always_comb begin
    active_map = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      active_map[i*SEL_W +: SEL_W] = active_r[i];
    end
  end

  assign cfg_err = cfg_err_r;

endmodule

// File: rtl/route_xbar.sv
// Runtime-programmable bit crossbar with one registered valid/ready stage.
// Beats accepted in a commit cycle are routed with the map in force before it.
module route_xbar
  import route_xbar_pkg::*;
#(
  parameter int unsigned IN_W        = 8,
  parameter int unsigned OUT_W       = 8,
  parameter logic        DEFAULT_BIT = 1'b0,
  parameter int unsigned SEL_W       = sel_width(IN_W),
  localparam int unsigned IDX_W      = idx_width(OUT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic             cfg_commit,
  output logic             cfg_err,
  output logic [31:0]      beat_count
);

  logic [OUT_W*SEL_W-1:0] active_map_s;
  logic [OUT_W-1:0]       routed_s;
  logic                   accept_s;
  logic                   out_valid_r;
  logic [OUT_W-1:0]       out_data_r;
  logic [31:0]            beat_count_r;

  route_map_bank #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SEL_W (SEL_W),
    .IDX_W (IDX_W)
  ) u_map (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_idx    (cfg_idx),
    .cfg_sel    (cfg_sel),
    .cfg_commit (cfg_commit),
    .cfg_err    (cfg_err),
    .active_map (active_map_s)
  );

  // Per-output-bit select; codes that match no input bit keep the default.
  always_comb begin
    routed_s = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      routed_s[i] = DEFAULT_BIT;
      for (int unsigned j = 0; j < IN_W; j++) begin
        routed_s[i] = (32'(active_map_s[i*SEL_W +: SEL_W]) == j) ? in_data[j] : routed_s[i];
      end
    end
  end

  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready;

  // Output register, handshake state and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      beat_count_r <= 32'd0;
    end else if (accept_s) begin
      out_valid_r  <= 1'b1;
      out_data_r   <= routed_s;
      beat_count_r <= beat_count_r + 32'd1;
    end else if (out_ready) begin
      out_valid_r  <= 1'b0;
    end
  end

  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign beat_count = beat_count_r;

endmodule
